// File: rtl/dm_arbiter_if.sv
// Requester-side port bundle for dm_arbiter: one instance per requester.
// master = requester (drives req and fields), slave = arbiter (drives ack/err/rdata).
interface dm_arbiter_if #(
  parameter int unsigned ADDR_W = 12
) ();
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ack;
  logic              err;
  logic [31:0]       rdata;

  modport master (
    output req, we, size, sext, addr, wdata,
    input  ack, err, rdata
  );

  modport slave (
    input  req, we, size, sext, addr, wdata,
    output ack, err, rdata
  );
endinterface

// File: rtl/dm_arbiter.sv
// dm_arbiter: shares one word-addressed dm_4k between a CPU LSU (m0) and a DMA/debug loader (m1).
// Optional: define DM_ARB_WPROT_EN to reject m1 stores below WPROT_TOP.
module dm_arbiter #(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned PRIO_MODE  = 0,
  parameter int unsigned STARVE_LIM = 4,
  parameter int unsigned WPROT_TOP  = 'h100
) (
  input  logic              clk,
  input  logic              rst,
  dm_arbiter_if.slave       m0,
  dm_arbiter_if.slave       m1,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_din,
  output logic [3:0]        mem_be,
  output logic              mem_wr,
  input  logic [31:0]       mem_dout
);
  localparam int unsigned CntW = (STARVE_LIM > 0) ? $clog2(STARVE_LIM + 1) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE_LIM);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
  state_e state_q, state_d;

  logic              lat_we_q, lat_sext_q, gnt_q, last_gnt_q;
  logic [1:0]        lat_size_q;
  logic [ADDR_W-1:0] lat_addr_q;
  logic [31:0]       lat_wdata_q;
  logic [CntW-1:0]   starve_q;
  logic              rsp_err_q;
  logic [31:0]       rsp_rdata_q;

  logic        any_req, win, align_err, wprot_err, acc_err;
  logic [1:0]  lane;
  logic [3:0]  be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign any_req = m0.req | m1.req;

  // win: 0 = m0, 1 = m1
  always_comb begin
    win = m1.req;
    if (m0.req && m1.req) begin
      if (PRIO_MODE == 0) win = ~last_gnt_q;
      else                win = (starve_q == CntMax);
    end
  end

  assign lane = lat_addr_q[1:0];

  always_comb begin
    align_err = 1'b0;
    be        = 4'b0000;
    unique case (lat_size_q)
      2'b00: be = 4'b0001 << lane;
      2'b01: begin
        align_err = lane[0];
        be        = lane[1] ? 4'b1100 : 4'b0011;
      end
      2'b10: begin
        align_err = (lane != 2'b00);
        be        = 4'b1111;
      end
      2'b11: align_err = 1'b1;
    endcase
    if (acc_err) be = 4'b0000;
  end

`ifdef DM_ARB_WPROT_EN
  assign wprot_err = gnt_q & lat_we_q & (32'(lat_addr_q) < WPROT_TOP);
`else
  assign wprot_err = 1'b0;
  logic unused_wprot;
  assign unused_wprot = ^WPROT_TOP;
`endif

  assign acc_err = align_err | wprot_err;

  // Halves only ever start at lane 0 or 2 once alignment is checked.
  assign ld_byte = mem_dout[{lane, 3'b000} +: 8];
  assign ld_half = mem_dout[{lane[1], 4'b0000} +: 16];

  always_comb begin
    unique case (lat_size_q)
      2'b00:   ld_data = {{24{lat_sext_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{lat_sext_q & ld_half[15]}}, ld_half};
      default: ld_data = mem_dout;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (any_req) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we_q    <= 1'b0;
      lat_sext_q  <= 1'b0;
      lat_size_q  <= 2'b00;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      gnt_q       <= 1'b0;
      last_gnt_q  <= 1'b1;
      starve_q    <= '0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      if (state_q == StIdle && any_req) begin
        gnt_q       <= win;
        last_gnt_q  <= win;
        lat_we_q    <= win ? m1.we    : m0.we;
        lat_sext_q  <= win ? m1.sext  : m0.sext;
        lat_size_q  <= win ? m1.size  : m0.size;
        lat_addr_q  <= win ? m1.addr  : m0.addr;
        lat_wdata_q <= win ? m1.wdata : m0.wdata;
        if (win)                              starve_q <= '0;
        else if (m1.req && starve_q != CntMax) starve_q <= starve_q + CntW'(1);
      end
      if (state_q == StAccess) begin
        rsp_err_q   <= acc_err;
        rsp_rdata_q <= (lat_we_q || acc_err) ? 32'h0 : ld_data;
      end
    end
  end

  // FSM outputs: everything comes from latched state only
  always_comb begin
    mem_addr = lat_addr_q[ADDR_W-1:2];
    mem_din  = lat_wdata_q;
    mem_be   = (state_q == StAccess) ? be : 4'b0000;
    mem_wr   = (state_q == StAccess) & lat_we_q & ~acc_err;
    m0.ack   = (state_q == StResp) & ~gnt_q;
    m1.ack   = (state_q == StResp) & gnt_q;
    m0.err   = (state_q == StResp) & ~gnt_q & rsp_err_q;
    m1.err   = (state_q == StResp) & gnt_q & rsp_err_q;
    m0.rdata = ((state_q == StResp) && !gnt_q) ? rsp_rdata_q : 32'h0;
    m1.rdata = ((state_q == StResp) && gnt_q) ? rsp_rdata_q : 32'h0;
  end
endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: directed cases plus random two-requester traffic checked every cycle
// against a transaction-level model (shadow memory, arbitration rule, 3-cycle access).
`timescale 1ns/1ps
module tb_dm_arbiter;
  localparam int unsigned AW     = 12;
  localparam int unsigned NWORDS = 1 << (AW - 2);
`ifdef DM_ARB_WPROT_EN
  localparam logic [AW-1:0] RST_ADDR = 12'h140;
`else
  localparam logic [AW-1:0] RST_ADDR = 12'h040;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic init_mem = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  dm_arbiter_if #(.ADDR_W(AW)) m0_if ();
  dm_arbiter_if #(.ADDR_W(AW)) m1_if ();
  dm_arbiter_if #(.ADDR_W(AW)) p0_if ();
  dm_arbiter_if #(.ADDR_W(AW)) p1_if ();

  logic [AW-3:0] mem_addr, p_addr;
  logic [31:0]   mem_din, mem_dout, p_din;
  logic [31:0]   p_dout = 32'h0;
  logic [3:0]    mem_be, p_be;
  logic          mem_wr, p_wr;

  dm_arbiter #(.ADDR_W(AW), .PRIO_MODE(0)) dut (
    .clk(clk), .rst(rst), .m0(m0_if), .m1(m1_if),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_be(mem_be), .mem_wr(mem_wr),
    .mem_dout(mem_dout)
  );

  dm_arbiter #(.ADDR_W(AW), .PRIO_MODE(1), .STARVE_LIM(4)) dut_p (
    .clk(clk), .rst(rst), .m0(p0_if), .m1(p1_if),
    .mem_addr(p_addr), .mem_din(p_din), .mem_be(p_be), .mem_wr(p_wr),
    .mem_dout(p_dout)
  );

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5C3_0F96;
  endfunction

  // dm_4k: byte/half lanes are taken from the low bits of din, placed by be
  logic [31:0] mem [NWORDS];
  assign mem_dout = mem[mem_addr];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < NWORDS; i++) mem[i] <= seed_word(i);
    end else if (mem_wr) begin
      case (mem_be)
        4'b0001: mem[mem_addr][7:0]   <= mem_din[7:0];
        4'b0010: mem[mem_addr][15:8]  <= mem_din[7:0];
        4'b0100: mem[mem_addr][23:16] <= mem_din[7:0];
        4'b1000: mem[mem_addr][31:24] <= mem_din[7:0];
        4'b0011: mem[mem_addr][15:0]  <= mem_din[15:0];
        4'b1100: mem[mem_addr][31:16] <= mem_din[15:0];
        4'b1111: mem[mem_addr]        <= mem_din;
        default: ;
      endcase
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic        err;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic [31:0] nword;
  } pred_t;

  function automatic pred_t predict(input int p, input logic we, input logic [1:0] size,
                                    input logic sext, input logic [AW-1:0] addr,
                                    input logic [31:0] wd, input logic [31:0] word);
    pred_t r;
    int a;
    logic [31:0] sh, nw;
    a = int'(addr[1:0]);
    r.err = (size == 2'b11) || (size == 2'b01 && (a % 2) == 1) || (size == 2'b10 && a != 0);
`ifdef DM_ARB_WPROT_EN
    if (p == 1 && we && addr < 12'h100) r.err = 1'b1;
`endif
    r.be = 4'b0000;
    r.rdata = 32'h0;
    nw = word;
    if (!r.err) begin
      case (size)
        2'b00:   r.be = 4'(1 << a);
        2'b01:   r.be = (a == 0) ? 4'b0011 : 4'b1100;
        default: r.be = 4'b1111;
      endcase
      sh = word >> (8 * a);
      if (we) begin
        case (size)
          2'b00:   nw[8*a +: 8]  = wd[7:0];
          2'b01:   nw[8*a +: 16] = wd[15:0];
          default: nw = wd;
        endcase
      end else begin
        case (size)
          2'b00:   r.rdata = sext ? 32'($signed(sh[7:0]))  : {24'h0, sh[7:0]};
          2'b01:   r.rdata = sext ? 32'($signed(sh[15:0])) : {16'h0, sh[15:0]};
          default: r.rdata = word;
        endcase
      end
    end
    r.nword = nw;
    return r;
  endfunction

  logic [31:0] ref_mem [NWORDS];
  int          ph, e_gnt, last_g, w;
  logic        e_err, e_wr, s_we, s_sext;
  logic [1:0]  s_size;
  logic [AW-1:0] s_addr;
  logic [31:0] s_wd;
  logic [3:0]  e_be;
  logic [AW-3:0] e_waddr;
  logic [31:0] e_din, e_rdata, e_nword;
  pred_t       pr;

  always @(posedge clk or posedge rst) begin
    if (init_mem) for (int i = 0; i < NWORDS; i++) ref_mem[i] <= seed_word(i);
    if (rst) begin
      ph     <= 0;
      last_g <= 1;
    end else begin
      case (ph)
        0: if (m0_if.req || m1_if.req) begin
          if (m0_if.req && m1_if.req) w = (last_g == 1) ? 0 : 1;
          else                        w = m1_if.req ? 1 : 0;
          s_we   = w ? m1_if.we    : m0_if.we;
          s_size = w ? m1_if.size  : m0_if.size;
          s_sext = w ? m1_if.sext  : m0_if.sext;
          s_addr = w ? m1_if.addr  : m0_if.addr;
          s_wd   = w ? m1_if.wdata : m0_if.wdata;
          pr = predict(w, s_we, s_size, s_sext, s_addr, s_wd, ref_mem[s_addr[AW-1:2]]);
          e_gnt   <= w;
          last_g  <= w;
          e_err   <= pr.err;
          e_be    <= pr.be;
          e_wr    <= s_we && !pr.err;
          e_waddr <= s_addr[AW-1:2];
          e_din   <= s_wd;
          e_rdata <= pr.rdata;
          e_nword <= pr.nword;
          ph      <= 1;
        end
        1: begin
          if (e_wr) ref_mem[e_waddr] <= e_nword;
          ph <= 2;
        end
        default: ph <= 0;
      endcase
    end
  end

  // Compare process: every cycle, half a period after the active edge
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_m0_ack", m0_if.ack, 0);
      chk("rst_m1_ack", m1_if.ack, 0);
      chk("rst_m0_err", m0_if.err, 0);
      chk("rst_m1_rdata", m1_if.rdata, 0);
      chk("rst_mem_wr", mem_wr, 0);
      chk("rst_mem_be", mem_be, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_din", mem_din, 0);
    end else begin
      case (ph)
        0: begin
          chk("idle_m0_ack", m0_if.ack, 0);
          chk("idle_m1_ack", m1_if.ack, 0);
          chk("idle_mem_wr", mem_wr, 0);
        end
        1: begin
          chk("acc_m0_ack", m0_if.ack, 0);
          chk("acc_m1_ack", m1_if.ack, 0);
          chk("acc_mem_wr", mem_wr, e_wr);
          chk("acc_mem_be", mem_be, e_be);
          chk("acc_mem_addr", mem_addr, e_waddr);
          chk("acc_mem_din", mem_din, e_din);
        end
        default: begin
          chk("rsp_m0_ack", m0_if.ack, e_gnt == 0);
          chk("rsp_m1_ack", m1_if.ack, e_gnt == 1);
          chk("rsp_err", e_gnt ? m1_if.err : m0_if.err, e_err);
          chk("rsp_rdata", e_gnt ? m1_if.rdata : m0_if.rdata, e_rdata);
          chk("rsp_mem_wr", mem_wr, 0);
        end
      endcase
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_req(input int p, input logic we, input logic [1:0] size, input logic sext,
                         input logic [AW-1:0] addr, input logic [31:0] wd);
    if (p == 0) begin
      m0_if.req = 1'b1; m0_if.we = we; m0_if.size = size;
      m0_if.sext = sext; m0_if.addr = addr; m0_if.wdata = wd;
    end else begin
      m1_if.req = 1'b1; m1_if.we = we; m1_if.size = size;
      m1_if.sext = sext; m1_if.addr = addr; m1_if.wdata = wd;
    end
  endtask

  task automatic clr_req(input int p);
    if (p == 0) m0_if.req = 1'b0;
    else        m1_if.req = 1'b0;
  endtask

  // p = -1 waits for either ack; who reports which port answered
  task automatic wait_ack(input int p, output int who, output logic err, output logic [31:0] rd);
    bit got = 0;
    who = -1; err = 1'b0; rd = 32'h0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if ((p == 0 || p == -1) && m0_if.ack) begin
        got = 1; who = 0; err = m0_if.err; rd = m0_if.rdata;
      end else if ((p == 1 || p == -1) && m1_if.ack) begin
        got = 1; who = 1; err = m1_if.err; rd = m1_if.rdata;
      end
    end
    if (!got) begin
      total++; bad++;
      $display("FAIL ack_timeout port %0d: got no ack expected ack within 20 cycles", p);
    end
  endtask

  task automatic xact(input int p, input logic we, input logic [1:0] size, input logic sext,
                      input logic [AW-1:0] addr, input logic [31:0] wd,
                      output logic err, output logic [31:0] rd);
    int who;
    set_req(p, we, size, sext, addr, wd);
    wait_ack(p, who, err, rd);
    clr_req(p);
  endtask

  task automatic rand_driver(input int p, input int n);
    logic [1:0] size;
    logic [AW-1:0] addr;
    logic err;
    logic [31:0] rd;
    int who;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      size = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      addr = AW'($urandom_range(0, 'h1FF));
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'b01) addr[0] = 1'b0;
        if (size == 2'b10) addr[1:0] = 2'b00;
      end
      set_req(p, 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom);
      wait_ack(p, who, err, rd);
      clr_req(p);
    end
  endtask

  task automatic prio_test();
    int seq[$];
    int exp_seq[10];
    exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    p0_if.req = 1'b1;
    p1_if.req = 1'b1;
    for (int c = 0; c < 40 && seq.size() < 10; c++) begin
      @(negedge clk);
      if (p0_if.ack) seq.push_back(0);
      if (p1_if.ack) seq.push_back(1);
    end
    p0_if.req = 1'b0;
    p1_if.req = 1'b0;
    chk("prio_ack_count", seq.size(), 10);
    foreach (seq[i]) if (i < 10) chk($sformatf("prio_grant%0d", i), seq[i], exp_seq[i]);
  endtask

  task automatic tie_test(input string nm, input int n);
    int who;
    logic err;
    logic [31:0] rd;
    set_req(0, 1'b0, 2'b10, 1'b0, 12'h300, 32'h0);
    set_req(1, 1'b0, 2'b10, 1'b0, 12'h380, 32'h0);
    for (int k = 0; k < n; k++) begin
      wait_ack(-1, who, err, rd);
      chk($sformatf("%s%0d", nm, k), who, k % 2);
      if (who >= 0) set_req(who, 1'b0, 2'b10, 1'b0, AW'(12'h300 + 4 * (k + 1)), 32'h0);
    end
    clr_req(0);
    clr_req(1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic err;
    logic [31:0] rd;
    bit saw_wr;
    m0_if.req = 0; m0_if.we = 0; m0_if.size = 0; m0_if.sext = 0; m0_if.addr = 0; m0_if.wdata = 0;
    m1_if.req = 0; m1_if.we = 0; m1_if.size = 0; m1_if.sext = 0; m1_if.addr = 0; m1_if.wdata = 0;
    p0_if.req = 0; p0_if.we = 0; p0_if.size = 2; p0_if.sext = 0; p0_if.addr = 0; p0_if.wdata = 0;
    p1_if.req = 0; p1_if.we = 0; p1_if.size = 2; p1_if.sext = 0; p1_if.addr = 4; p1_if.wdata = 0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    init_mem = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    prio_test();
    tie_test("tie_rr", 4);

    xact(0, 1, 2'b10, 0, 12'h010, 32'hDEAD_BEEF, err, rd);
    chk("sw_err", err, 0);
    xact(0, 0, 2'b10, 0, 12'h010, 32'h0, err, rd);
    chk("lw_data", rd, 32'hDEAD_BEEF);

    xact(0, 1, 2'b10, 0, 12'h020, 32'h8081_7F02, err, rd);
    xact(0, 0, 2'b00, 1, 12'h023, 32'h0, err, rd);
    chk("lb_data", rd, 32'hFFFF_FF80);
    xact(0, 0, 2'b00, 0, 12'h023, 32'h0, err, rd);
    chk("lbu_data", rd, 32'h0000_0080);
    xact(0, 0, 2'b01, 1, 12'h022, 32'h0, err, rd);
    chk("lh_data", rd, 32'hFFFF_8081);
    xact(0, 0, 2'b01, 0, 12'h020, 32'h0, err, rd);
    chk("lhu_data", rd, 32'h0000_7F02);
    xact(0, 1, 2'b00, 0, 12'h021, 32'h0000_0055, err, rd);
    xact(0, 0, 2'b10, 0, 12'h020, 32'h0, err, rd);
    chk("sb_merge", rd, 32'h8081_5502);

    xact(0, 1, 2'b01, 0, 12'h031, 32'h1111_2222, err, rd);
    chk("sh_mis_err", err, 1);
    chk("sh_mis_rdata", rd, 0);
    xact(0, 1, 2'b10, 0, 12'h022, 32'h3333_4444, err, rd);
    chk("sw_mis_err", err, 1);
    xact(0, 0, 2'b11, 0, 12'h040, 32'h0, err, rd);
    chk("size11_err", err, 1);
    chk("size11_rdata", rd, 0);

    // Reset in the middle of an m1 store's memory cycle
    set_req(1, 1, 2'b10, 0, RST_ADDR, 32'h1234_5678);
    saw_wr = 0;
    for (int c = 0; c < 10 && !saw_wr; c++) begin
      @(negedge clk);
      if (mem_wr) saw_wr = 1;
    end
    chk("rst_mid_saw_wr", saw_wr, 1);
    #2 rst = 1'b1;
    clr_req(1);
    #1;
    chk("rst_mid_mem_wr", mem_wr, 0);
    chk("rst_mid_mem_be", mem_be, 0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_mid_no_ack", m1_if.ack, 0);
    end
    tie_test("tie_after_rst", 2);
    xact(0, 0, 2'b10, 0, RST_ADDR, 32'h0, err, rd);
    chk("rst_mid_word_kept", rd, seed_word(int'(RST_ADDR >> 2)));

    xact(1, 1, 2'b10, 0, 12'h0FC, 32'hA1A2_A3A4, err, rd);
`ifdef DM_ARB_WPROT_EN
    chk("wprot_low_err", err, 1);
    xact(0, 0, 2'b10, 0, 12'h0FC, 32'h0, err, rd);
    chk("wprot_low_kept", rd, seed_word(63));
`else
    chk("wprot_low_err", err, 0);
    xact(0, 0, 2'b10, 0, 12'h0FC, 32'h0, err, rd);
    chk("wprot_low_written", rd, 32'hA1A2_A3A4);
`endif
    xact(1, 1, 2'b10, 0, 12'h100, 32'hB1B2_B3B4, err, rd);
    chk("wprot_top_err", err, 0);
    xact(0, 0, 2'b10, 0, 12'h100, 32'h0, err, rd);
    chk("wprot_top_written", rd, 32'hB1B2_B3B4);
    xact(0, 1, 2'b10, 0, 12'h0FC, 32'h0BAD_F00D, err, rd);
    chk("wprot_m0_err", err, 0);
    xact(0, 0, 2'b10, 0, 12'h0FC, 32'h0, err, rd);
    chk("wprot_m0_written", rd, 32'h0BAD_F00D);

    fork
      rand_driver(0, 150);
      rand_driver(1, 150);
    join

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within 1 ms");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares one dm_4k data memory (word-addressed, byte-enable write, combinational read) between two requesters.
  - m0: CPU load/store unit.
  - m1: DMA/debug loader.
- Arbitrates requests, generates byte enables from size and address, checks alignment, and performs the write.
- Extracts and sign/zero-extends read data.
- Returns a registered ack to the granted requester.

Parameters:
ADDR_W, 12, byte-address width; memory word address is ADDR_W-1:2
PRIO_MODE, 0, 0 = round-robin; 1 = m0 fixed priority with starvation guard
STARVE_LIM, 4, PRIO_MODE=1 only: consecutive lost arbitrations of m1 before m1 is forced through
WPROT_TOP, 12'h100, used only with DM_ARB_WPROT_EN: protected byte-address limit

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-high reset
m0_req  in  1  request; held with all m0 fields stable until m0_ack
m0_we  in  1  1 = store, 0 = load
m0_size  in  2  00 byte, 01 half, 10 word, 11 illegal
m0_sext  in  1  load sign-extend (lb/lh) vs zero-extend (lbu/lhu)
m0_addr  in  ADDR_W  byte address
m0_wdata  in  32  store data, right-justified
m0_ack  out  1  one-cycle completion pulse
m0_err  out  1  valid with m0_ack: access rejected
m0_rdata  out  32  valid with m0_ack: extended load data, 0 on store or error
m1_req, m1_we, m1_size, m1_sext, m1_addr, m1_wdata, m1_ack, m1_err, m1_rdata: same as m0
mem_addr  out  ADDR_W-2  word address to memory
mem_din  out  32  store data, unshifted; memory selects the lane from mem_be
mem_be  out  4  byte enables
mem_wr  out  1  memory write strobe
mem_dout  in  32  memory read word

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
  - IDLE: if any req, arbitrate, latch the winner's fields and the grant id, go to ACCESS. Otherwise stay.
  - ACCESS, one cycle:
    - mem_addr, mem_din and mem_be are driven from the latch.
    - mem_wr = latched we & ~err.
    - For loads, mem_dout is extracted and registered into rdata at the end of the cycle.
    - Next state is RESP.
  - RESP: the granted ack is 1 for exactly this cycle, with err and rdata valid. Next state is IDLE. Requests are not sampled in RESP.
- Latency:
  - req seen in IDLE at cycle T -> memory written at the edge ending T+1 -> ack during T+2.
  - Throughput is 1 access per 3 cycles.
  - A requester must deassert or change req by T+3.
- Byte enables, with a = addr[1:0]:
  - byte: 0001 << a.
  - half: a=0 gives 0011; a=2 gives 1100.
  - word: 1111.
- Error cases: half with a[0]=1, word with a!=0, or size=11.
  - err=1, mem_be=0, mem_wr=0, rdata=0.
  - ack is still given at T+2.
- Load extraction:
  - byte: dout[8a+7:8a].
  - half: dout[8a+15:8a].
  - Bit 7 (byte) or bit 15 (half) is replicated when sext=1, else zero-filled.
  - Word loads return dout unchanged; sext is ignored.
- Arbitration, PRIO_MODE=0:
  - A single requester wins.
  - If both request, the one not granted last wins.
  - last_grant resets to m1, so m0 wins the first tie.
- Arbitration, PRIO_MODE=1:
  - m0 wins ties, unless starve_cnt == STARVE_LIM; then m1 wins.
  - starve_cnt increments when m1 requests and loses. It saturates at STARVE_LIM.
  - starve_cnt clears when m1 is granted.
- Outputs depend only on latched state: ack, err, rdata and mem_* never combinationally follow req inputs.
- Reset is asynchronous and effective in any state, including mid-ACCESS.
  - state=IDLE; all acks, errs, rdata = 0.
  - Latch cleared, so mem_addr, mem_din, mem_be = 0 and mem_wr = 0 immediately.
  - last_grant = m1, starve_cnt = 0.
  - An interrupted write is not performed. The requester re-issues it after reset.

Optional Feature:
DM_ARB_WPROT_EN:
- Defined: an m1 store with addr < WPROT_TOP is rejected with err=1, mem_wr=0, ack as normal. m1 loads and all m0 accesses are unaffected.
- Undefined: no protection check; WPROT_TOP is unused.

Test Plan:
1. m0 sw to addr 0x010, wdata 0xDEADBEEF -> mem_wr=1, mem_be=1111, mem_addr=4 at T+1; m0_ack=1, err=0 at T+2; a following lw from 0x010 returns 0xDEADBEEF.
2. Memory word 0x8081_7F02 at addr 0x020: lb 0x023 -> 0xFFFFFF80; lbu 0x023 -> 0x00000080; lh 0x022 -> 0xFFFF8081; lhu 0x020 -> 0x00007F02.
3. m0 sh to 0x031, then sw to 0x022 -> each acked with err=1, mem_wr never asserted, rdata=0.
4. Both req every cycle, PRIO_MODE=0 -> grants alternate m0, m1, m0, m1. PRIO_MODE=1, STARVE_LIM=4 -> four m0 grants then one m1 grant, repeating.
5. rst pulsed mid-ACCESS of an m1 store to 0x040 -> mem_wr drops immediately, no ack, word 0x040 unchanged, next tie goes to m0.
6. With DM_ARB_WPROT_EN: m1 sw to 0x0FC -> err=1, no write; m1 sw to 0x100 -> written; m0 sw to 0x0FC -> written.
